cpu_core: RTL

Parametrised multicycle CPU core. It succeeds the fixed 8-bit CPU/register-file pair and generalises data width and instruction-memory depth. It adds a host load port for instruction memory and registers, start/halt control, conditional branches, and zero/carry flags. It sits at the top of the datapath and is driven by the testbench or a host loader.

---
 rtl/cpu_core_if.sv | 30 +++
 rtl/cpu_core.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cpu_core_if.sv
// Host-side bundle for cpu_core: program/debug load, start control and status.
interface cpu_core_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned IMEM_AW = 8
);
  logic               start;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [15:0]        imem_wdata;
  logic               dbg_we;
  logic [2:0]         dbg_addr;
  logic [DATA_W-1:0]  dbg_wdata;
  logic [DATA_W-1:0]  dbg_rdata;
  logic [DATA_W-1:0]  result;
  logic               carry_out;
  logic               zero_flag;
  logic [IMEM_AW-1:0] pc;
  logic               busy;
  logic               halted;

  modport master (
    output start, imem_we, imem_addr, imem_wdata, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, result, carry_out, zero_flag, pc, busy, halted
  );

  modport slave (
    input  start, imem_we, imem_addr, imem_wdata, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, result, carry_out, zero_flag, pc, busy, halted
  );
endinterface

// File: rtl/cpu_core.sv
// Multicycle CPU core: FETCH/DECODE/EXECUTE/WRITEBACK, 8 registers, 16-bit
// instructions, zero/carry flags and a host load port usable while stopped.
module cpu_core #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned IMEM_AW = 8
) (
  input  logic     clk,
  input  logic     reset,
  cpu_core_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALTED
  } state_t;

  state_t             r_state, w_next;
  logic [15:0]        r_imem [2**IMEM_AW];
  logic [DATA_W-1:0]  r_rf [8];
  logic [15:0]        r_ir;
  logic [DATA_W-1:0]  r_a, r_b, r_wb, r_result;
  logic               r_carry, r_zero;
  logic [IMEM_AW-1:0] r_pc;

  logic               w_host_ok, w_busy, w_halted;
  logic [3:0]         w_op;
  logic [2:0]         w_rd, w_rs1, w_rs2;
  logic [7:0]         w_imm;
  logic [DATA_W:0]    w_sum, w_diff;
  logic [DATA_W-1:0]  w_alu;
  logic               w_alu_c, w_alu_op, w_wr_op, w_take;

  assign w_op  = r_ir[15:12];
  assign w_rd  = r_ir[11:9];
  assign w_rs1 = r_ir[8:6];
  assign w_rs2 = r_ir[5:3];
  assign w_imm = r_ir[7:0];

  assign w_host_ok = (r_state == S_IDLE) || (r_state == S_HALTED);
  assign w_alu_op  = (w_op >= 4'h1) && (w_op <= 4'h5);
  assign w_wr_op   = (w_op >= 4'h1) && (w_op <= 4'h7);
  assign w_take    = (w_op == 4'h8) || ((w_op == 4'h9) && r_zero) ||
                     ((w_op == 4'hA) && r_carry);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALTED: if (bus.start) w_next = S_FETCH;
      S_FETCH:          w_next = S_DECODE;
      S_DECODE:         w_next = S_EXECUTE;
      S_EXECUTE:        w_next = (w_op == 4'hF) ? S_HALTED : S_WRITEBACK;
      S_WRITEBACK:      w_next = S_FETCH;
      default:          w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK: w_busy = 1'b1;
      S_HALTED:                                  w_halted = 1'b1;
      default: ;
    endcase
  end

  // Extra top bit of the widened sum/difference is carry for ADD, borrow for SUB.
  always_comb begin
    w_sum   = {1'b0, r_a} + {1'b0, r_b};
    w_diff  = {1'b0, r_a} - {1'b0, r_b};
    w_alu   = '0;
    w_alu_c = 1'b0;
    case (w_op)
      4'h1: begin w_alu = w_sum[DATA_W-1:0];  w_alu_c = w_sum[DATA_W];  end
      4'h2: begin w_alu = w_diff[DATA_W-1:0]; w_alu_c = w_diff[DATA_W]; end
      4'h3: w_alu = r_a & r_b;
      4'h4: w_alu = r_a | r_b;
      4'h5: w_alu = r_a ^ r_b;
      default: ;
    endcase
  end

  // Instruction memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_host_ok && bus.imem_we) r_imem[bus.imem_addr] <= bus.imem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_wb     <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_pc     <= '0;
      r_rf     <= '{default: '0};
    end else begin
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (bus.dbg_we) r_rf[bus.dbg_addr] <= bus.dbg_wdata;
          if (bus.start)  r_pc <= '0;
        end
        S_FETCH: r_ir <= r_imem[r_pc];
        S_DECODE: begin
          r_a <= r_rf[w_rs1];
          r_b <= r_rf[w_rs2];
        end
        S_EXECUTE: begin
          if (w_alu_op) begin
            r_result <= w_alu;
            r_carry  <= w_alu_c;
            r_zero   <= (w_alu == '0);
          end
          r_wb <= (w_op == 4'h6) ? DATA_W'(w_imm) :
                  (w_op == 4'h7) ? r_a : w_alu;
        end
        S_WRITEBACK: begin
          if (w_wr_op) r_rf[w_rd] <= r_wb;
          r_pc <= w_take ? w_imm[IMEM_AW-1:0] : r_pc + IMEM_AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.dbg_rdata = r_rf[bus.dbg_addr];
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry;
  assign bus.zero_flag = r_zero;
  assign bus.pc        = r_pc;
  assign bus.busy      = w_busy;
  assign bus.halted    = w_halted;

endmodule
